// File: rtl/sauria_sramc_pkg.sv
// rtl/sauria_sramc_pkg.sv - shared types for the SRAMC port arbiter slice
//
// Purpose: read-owner enum and the {valid, owner} tag that rides the read
//          latency pipe so returning SRAM data can be steered to its requester.
// Ports:   none (package).

package sauria_sramc_pkg;

  typedef enum logic {
    OWN_PSM = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/sramc_rsp_fifo.sv
// rtl/sramc_rsp_fifo.sv - show-ahead synchronous FIFO for DMA read responses
//
// Purpose: holds DMA read data until the DMA side accepts it; head is visible
//          combinationally while the FIFO is non-empty.
// Ports:   i_clk/i_rst   clock, synchronous active-high reset
//          i_push/i_data write side; a push while full is dropped unless a
//                        pop happens in the same cycle
//          i_pop         remove head (ignored when empty)
//          o_full/o_empty occupancy flags
//          o_head        current head entry

module sramc_rsp_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sramc_port_arbiter.sv
// rtl/sramc_port_arbiter.sv - shares the single SRAMC port between PSM and DMA
//
// Purpose: PSM has strict, zero-latency priority; DMA requests fill idle
//          cycles. Reads are tagged by owner; DMA read data is buffered in a
//          credit-protected FIFO so DMA backpressure never stalls the SRAM.
// Ports:   i_clk/i_rst        clock, synchronous active-high reset
//          i_psm_*            PSM access (no backpressure)
//          o_psm_rdata        SRAM read data pass-through to PSM
//          i/o_dma_req_*      DMA request channel (valid/ready)
//          i/o_dma_rsp_*      DMA read response channel (valid/ready)
//          o_mem_*/i_mem_rdata SRAM macro port
//          o_err              sticky protocol error

module sramc_port_arbiter
  import sauria_sramc_pkg::*;
#(
  parameter int ADRC_W    = 8,
  parameter int SRAMC_W   = 96,
  parameter int SRAMC_N   = 2,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = RD_LAT + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ADRC_W-1:0]  i_psm_addr,
  input  logic               i_psm_wren,
  input  logic               i_psm_rden,
  input  logic [SRAMC_N-1:0] i_psm_wmask,
  input  logic [SRAMC_W-1:0] i_psm_wdata,
  output logic [SRAMC_W-1:0] o_psm_rdata,
  input  logic               i_dma_req_valid,
  output logic               o_dma_req_ready,
  input  logic               i_dma_req_we,
  input  logic [ADRC_W-1:0]  i_dma_req_addr,
  input  logic [SRAMC_N-1:0] i_dma_req_wmask,
  input  logic [SRAMC_W-1:0] i_dma_req_wdata,
  output logic               o_dma_rsp_valid,
  input  logic               i_dma_rsp_ready,
  output logic [SRAMC_W-1:0] o_dma_rsp_data,
  output logic [ADRC_W-1:0]  o_mem_addr,
  output logic               o_mem_wren,
  output logic               o_mem_rden,
  output logic [SRAMC_N-1:0] o_mem_wmask,
  output logic [SRAMC_W-1:0] o_mem_wdata,
  input  logic [SRAMC_W-1:0] i_mem_rdata,
  output logic               o_err
);

  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  logic             w_psm_act;
  logic             w_dma_fire;
  logic             w_dma_rd_fire;
  owner_e           w_owner;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_overflow;
  logic [CRD_W-1:0] r_credits;
  tag_t             r_tag [RD_LAT];
  logic             r_err;

  assign w_psm_act       = i_psm_wren | i_psm_rden;
  assign o_dma_req_ready = ~w_psm_act & ~i_rst & (r_credits != '0);
  assign w_dma_fire      = i_dma_req_valid & o_dma_req_ready;
  assign w_dma_rd_fire   = w_dma_fire & ~i_dma_req_we;

  // Port mux. Held at zero during reset so the macro sees no access even if
  // the PSM is already driving requests.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wren  = 1'b0;
    o_mem_rden  = 1'b0;
    o_mem_wmask = '0;
    o_mem_wdata = '0;
    w_owner     = OWN_PSM;
    if (!i_rst) begin
      if (w_psm_act) begin
        o_mem_addr  = i_psm_addr;
        o_mem_wren  = i_psm_wren;
        o_mem_rden  = i_psm_rden & ~i_psm_wren;
        o_mem_wmask = i_psm_wmask;
        o_mem_wdata = i_psm_wdata;
      end else if (w_dma_fire) begin
        o_mem_addr  = i_dma_req_addr;
        o_mem_wren  = i_dma_req_we;
        o_mem_rden  = ~i_dma_req_we;
        o_mem_wmask = i_dma_req_wmask;
        o_mem_wdata = i_dma_req_wdata;
        w_owner     = OWN_DMA;
      end
    end
  end

  // Tag pipe: last stage lines up with i_mem_rdata for the tagged read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= tag_t'{valid: o_mem_rden, owner: w_owner};
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_psm_rdata = i_mem_rdata;
  assign w_push      = r_tag[RD_LAT-1].valid & (r_tag[RD_LAT-1].owner == OWN_DMA);
  assign w_pop       = o_dma_rsp_valid & i_dma_rsp_ready;
  assign w_overflow  = w_push & w_full & ~w_pop;

  sramc_rsp_fifo #(
    .WIDTH (SRAMC_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_mem_rdata),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (o_dma_rsp_data)
  );

  assign o_dma_rsp_valid = ~w_empty;

  // One credit per FIFO slot: reserved at read issue, returned on pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_credits <= CRD_W'(RSP_DEPTH);
    end else begin
      case ({w_dma_rd_fire, w_pop})
        2'b10:   r_credits <= r_credits - CRD_W'(1);
        2'b01:   r_credits <= r_credits + CRD_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if ((i_psm_wren & i_psm_rden) | w_overflow) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_sramc_port_arbiter.sv
// tb/tb_sramc_port_arbiter.sv - directed self-checking bench for sramc_port_arbiter

module tb_sramc_port_arbiter;

  localparam int ADRC_W    = 8;
  localparam int SRAMC_W   = 96;
  localparam int SRAMC_N   = 2;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADRC_W-1:0]  psm_addr;
  logic               psm_wren;
  logic               psm_rden;
  logic [SRAMC_N-1:0] psm_wmask;
  logic [SRAMC_W-1:0] psm_wdata;
  logic [SRAMC_W-1:0] psm_rdata;
  logic               dma_req_valid;
  logic               dma_req_ready;
  logic               dma_req_we;
  logic [ADRC_W-1:0]  dma_req_addr;
  logic [SRAMC_N-1:0] dma_req_wmask;
  logic [SRAMC_W-1:0] dma_req_wdata;
  logic               dma_rsp_valid;
  logic               dma_rsp_ready;
  logic [SRAMC_W-1:0] dma_rsp_data;
  logic [ADRC_W-1:0]  mem_addr;
  logic               mem_wren;
  logic               mem_rden;
  logic [SRAMC_N-1:0] mem_wmask;
  logic [SRAMC_W-1:0] mem_wdata;
  logic [SRAMC_W-1:0] mem_rdata;
  logic               err;

  logic [SRAMC_W-1:0] sram_d1;
  logic [SRAMC_W-1:0] sram_d2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sramc_port_arbiter #(
    .ADRC_W    (ADRC_W),
    .SRAMC_W   (SRAMC_W),
    .SRAMC_N   (SRAMC_N),
    .RD_LAT    (RD_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_psm_addr      (psm_addr),
    .i_psm_wren      (psm_wren),
    .i_psm_rden      (psm_rden),
    .i_psm_wmask     (psm_wmask),
    .i_psm_wdata     (psm_wdata),
    .o_psm_rdata     (psm_rdata),
    .i_dma_req_valid (dma_req_valid),
    .o_dma_req_ready (dma_req_ready),
    .i_dma_req_we    (dma_req_we),
    .i_dma_req_addr  (dma_req_addr),
    .i_dma_req_wmask (dma_req_wmask),
    .i_dma_req_wdata (dma_req_wdata),
    .o_dma_rsp_valid (dma_rsp_valid),
    .i_dma_rsp_ready (dma_rsp_ready),
    .o_dma_rsp_data  (dma_rsp_data),
    .o_mem_addr      (mem_addr),
    .o_mem_wren      (mem_wren),
    .o_mem_rden      (mem_rden),
    .o_mem_wmask     (mem_wmask),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .o_err           (err)
  );

  // SRAM stand-in: returns an address-derived pattern two cycles after rden.
  function automatic logic [SRAMC_W-1:0] pat(input logic [ADRC_W-1:0] a);
    return {24'hA5A5A5, a, 56'h0, ~a};
  endfunction

  always @(posedge clk) begin
    sram_d1 <= mem_rden ? pat(mem_addr) : '0;
    sram_d2 <= sram_d1;
  end
  assign mem_rdata = sram_d2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    psm_addr      = '0;
    psm_wren      = 1'b0;
    psm_rden      = 1'b0;
    psm_wmask     = '0;
    psm_wdata     = '0;
    dma_req_valid = 1'b0;
    dma_req_we    = 1'b0;
    dma_req_addr  = '0;
    dma_req_wmask = '0;
    dma_req_wdata = '0;
    dma_rsp_ready = 1'b0;

    // Reset state, with a pending DMA request and an active PSM write.
    tick();
    tick();
    dma_req_valid = 1'b1;
    psm_wren      = 1'b1;
    psm_addr      = 8'h21;
    #1;
    chk("rst_mem_wren", 128'(mem_wren), 128'd0);
    chk("rst_mem_rden", 128'(mem_rden), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_req_ready", 128'(dma_req_ready), 128'd0);
    chk("rst_rsp_valid", 128'(dma_rsp_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_credits", 128'(dut.r_credits), 128'd2);
    dma_req_valid = 1'b0;
    psm_wren      = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 1: PSM write beats a waiting DMA write; DMA fires once PSM is idle.
    psm_wren      = 1'b1;
    psm_addr      = 8'h12;
    psm_wmask     = 2'b10;
    psm_wdata     = 96'hABC;
    dma_req_valid = 1'b1;
    dma_req_we    = 1'b1;
    dma_req_addr  = 8'h30;
    dma_req_wmask = 2'b01;
    dma_req_wdata = 96'h777;
    #1;
    chk("t1_psm_wren", 128'(mem_wren), 128'd1);
    chk("t1_psm_addr", 128'(mem_addr), 128'h12);
    chk("t1_psm_wmask", 128'(mem_wmask), 128'd2);
    chk("t1_psm_wdata", 128'(mem_wdata), 128'hABC);
    chk("t1_req_blocked", 128'(dma_req_ready), 128'd0);
    tick();
    psm_wren = 1'b0;
    #1;
    chk("t1_req_ready", 128'(dma_req_ready), 128'd1);
    chk("t1_dma_wren", 128'(mem_wren), 128'd1);
    chk("t1_dma_rden", 128'(mem_rden), 128'd0);
    chk("t1_dma_addr", 128'(mem_addr), 128'h30);
    chk("t1_dma_wdata", 128'(mem_wdata), 128'h777);
    tick();
    dma_req_valid = 1'b0;
    #1;
    chk("t1_idle_wren", 128'(mem_wren), 128'd0);
    chk("t1_credits", 128'(dut.r_credits), 128'd2);

    // 2: PSM read, data two cycles later, FIFO untouched.
    psm_rden = 1'b1;
    psm_addr = 8'h05;
    #1;
    chk("t2_rden", 128'(mem_rden), 128'd1);
    chk("t2_addr", 128'(mem_addr), 128'h05);
    tick();
    psm_rden = 1'b0;
    tick();
    chk("t2_psm_rdata", 128'(psm_rdata), 128'(pat(8'h05)));
    tick();
    chk("t2_no_rsp", 128'(dma_rsp_valid), 128'd0);
    chk("t2_credits", 128'(dut.r_credits), 128'd2);

    // 3/4: three DMA reads against two credits, DMA holding off responses.
    dma_rsp_ready = 1'b0;
    dma_req_valid = 1'b1;
    dma_req_we    = 1'b0;
    dma_req_addr  = 8'h01;
    #1;
    chk("t3_rd1_ready", 128'(dma_req_ready), 128'd1);
    chk("t3_rd1_addr", 128'(mem_addr), 128'h01);
    tick();
    dma_req_addr = 8'h02;
    #1;
    chk("t3_rd2_rden", 128'(mem_rden), 128'd1);
    tick();
    dma_req_addr = 8'h03;
    #1;
    chk("t3_rd3_blocked", 128'(dma_req_ready), 128'd0);
    chk("t3_rd3_no_rden", 128'(mem_rden), 128'd0);
    tick();
    chk("t3_rsp1_valid", 128'(dma_rsp_valid), 128'd1);
    chk("t3_rsp1_data", 128'(dma_rsp_data), 128'(pat(8'h01)));
    tick();
    chk("t3_hold_data", 128'(dma_rsp_data), 128'(pat(8'h01)));
    chk("t3_credits0", 128'(dut.r_credits), 128'd0);
    dma_rsp_ready = 1'b1;
    #1;
    chk("t3_still_blocked", 128'(dma_req_ready), 128'd0);
    tick();
    chk("t3_rsp2_data", 128'(dma_rsp_data), 128'(pat(8'h02)));
    chk("t4_credits1", 128'(dut.r_credits), 128'd1);
    chk("t4_ready", 128'(dma_req_ready), 128'd1);
    chk("t4_rd3_addr", 128'(mem_addr), 128'h03);
    tick();
    dma_req_valid = 1'b0;
    #1;
    chk("t4_credits_held", 128'(dut.r_credits), 128'd1);
    chk("t4_empty", 128'(dma_rsp_valid), 128'd0);
    chk("t4_no_err", 128'(err), 128'd0);
    tick();
    tick();
    chk("t3_rsp3_data", 128'(dma_rsp_data), 128'(pat(8'h03)));
    chk("t3_rsp3_valid", 128'(dma_rsp_valid), 128'd1);
    tick();
    chk("t3_drained", 128'(dma_rsp_valid), 128'd0);
    chk("t3_credits2", 128'(dut.r_credits), 128'd2);

    // 5: simultaneous PSM read and write -> write wins, sticky error.
    psm_wren  = 1'b1;
    psm_rden  = 1'b1;
    psm_addr  = 8'h40;
    psm_wmask = 2'b11;
    psm_wdata = 96'h55;
    #1;
    chk("t5_wren", 128'(mem_wren), 128'd1);
    chk("t5_rden", 128'(mem_rden), 128'd0);
    chk("t5_err_before", 128'(err), 128'd0);
    tick();
    psm_wren = 1'b0;
    psm_rden = 1'b0;
    #1;
    chk("t5_err_set", 128'(err), 128'd1);
    tick();
    tick();
    chk("t5_err_held", 128'(err), 128'd1);

    // 6: reset with two DMA reads in flight.
    dma_rsp_ready = 1'b0;
    dma_req_valid = 1'b1;
    dma_req_we    = 1'b0;
    dma_req_addr  = 8'h07;
    tick();
    dma_req_addr = 8'h08;
    tick();
    dma_req_valid = 1'b0;
    rst           = 1'b1;
    #1;
    chk("t6_ready_in_rst", 128'(dma_req_ready), 128'd0);
    tick();
    chk("t6_rsp_valid", 128'(dma_rsp_valid), 128'd0);
    chk("t6_credits", 128'(dut.r_credits), 128'd2);
    chk("t6_err_clr", 128'(err), 128'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_no_late_push", 128'(dma_rsp_valid), 128'd0);
    chk("t6_credits_after", 128'(dut.r_credits), 128'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sramc_port_arbiter.md
Name: sramc_port_arbiter

Overview:
- Sits directly downstream of the partial-sum manager (PSM), between it and the single-port SRAMC macro.
- Shares the SRAMC port between the PSM (strict priority, no backpressure) and an external DMA request/response channel.
- Tags every read by owner and routes read data back to it. DMA read data passes through a small credit-protected response FIFO, so DMA backpressure never blocks the SRAM.

Parameters:
- ADRC_W, 8: SRAMC address width
- SRAMC_W, 96: SRAMC data width
- SRAMC_N, 2: write-mask lanes (SRAMC_W/OC_W)
- RD_LAT, 1: SRAM read latency in cycles, 1..4
- RSP_DEPTH, RD_LAT+1: DMA response FIFO depth

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_psm_addr  in  ADRC_W  PSM address
- i_psm_wren  in  1  PSM write request
- i_psm_rden  in  1  PSM read request
- i_psm_wmask  in  SRAMC_N  PSM write mask
- i_psm_wdata  in  SRAMC_W  PSM write data
- o_psm_rdata  out  SRAMC_W  read data to PSM
- i_dma_req_valid  in  1  DMA request valid
- o_dma_req_ready  out  1  DMA request accepted
- i_dma_req_we  in  1  1 = write, 0 = read
- i_dma_req_addr  in  ADRC_W  DMA address
- i_dma_req_wmask  in  SRAMC_N  DMA write mask
- i_dma_req_wdata  in  SRAMC_W  DMA write data
- o_dma_rsp_valid  out  1  DMA read data valid
- i_dma_rsp_ready  in  1  DMA ready for read data
- o_dma_rsp_data  out  SRAMC_W  DMA read data
- o_mem_addr  out  ADRC_W  SRAM address
- o_mem_wren  out  1  SRAM write enable
- o_mem_rden  out  1  SRAM read enable
- o_mem_wmask  out  SRAMC_N  SRAM write mask
- o_mem_wdata  out  SRAMC_W  SRAM write data
- i_mem_rdata  in  SRAMC_W  SRAM read data
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: i_rst sampled on rising i_clk only. Clears the tag pipe, FIFO, credit counter and o_err. Reset mid-operation drops in-flight reads silently; no response is issued for them.
- Outputs at reset: o_mem_* = 0, o_dma_req_ready = 0, o_dma_rsp_valid = 0, o_err = 0.
- Arbitration is combinational, with no added latency on the PSM path:
  - psm_act = i_psm_wren | i_psm_rden.
  - When psm_act = 1, the PSM drives o_mem_* unchanged and o_mem_wren has priority over o_mem_rden.
  - o_dma_req_ready = !psm_act & !i_rst & (credits > 0).
  - A DMA transfer fires on i_dma_req_valid & o_dma_req_ready and drives o_mem_*: wren = we, rden = !we.
  - When no access is granted, o_mem_wren and o_mem_rden = 0; addr/wmask/wdata = 0.
- Protocol error: i_psm_wren & i_psm_rden in the same cycle sets o_err, which stays set until reset; the write is performed.
- Tag pipe: RD_LAT-stage shift register of {valid, owner}. Stage 0 is loaded with {o_mem_rden, owner} every cycle. The last stage aligns with i_mem_rdata.
- o_psm_rdata = i_mem_rdata, pass-through with no register. The PSM registers it itself.
- Response FIFO:
  - Pushed when the last tag stage is valid with owner = DMA.
  - Popped on o_dma_rsp_valid & i_dma_rsp_ready.
  - o_dma_rsp_valid = FIFO not empty; o_dma_rsp_data = FIFO head (show-ahead).
  - Data order equals request order.
- Credits:
  - Counter width $clog2(RSP_DEPTH+1); reset value RSP_DEPTH.
  - Decremented on each DMA read fire; incremented on each pop.
  - Fire and pop in the same cycle leave it unchanged.
  - Guarantees a push never hits a full FIFO. An overflow attempt still sets o_err (assertion in the bench).
- DMA writes consume no credit. A DMA write and a pop may occur in the same cycle.
- The FIFO pointers and credit counter wrap cleanly at RSP_DEPTH.

Decomposition:
- sauria_sramc_pkg: owner enum (OWN_PSM = 0, OWN_DMA = 1) and the tag struct {valid, owner}.
- Sub-module sramc_rsp_fifo: synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty/head. Instantiated once.

Test Plan:
1. PSM write addr 0x12, mask 2'b10, data 0xABC while DMA valid -> o_mem_wren = 1, addr 0x12; o_dma_req_ready = 0 that cycle; the DMA request fires the next cycle once the PSM is idle.
2. PSM read addr 0x05 with RD_LAT = 2 -> rdata at cycle +2 appears on o_psm_rdata; FIFO not pushed; o_dma_rsp_valid stays 0.
3. Three back-to-back DMA reads 0x01, 0x02, 0x03, RSP_DEPTH = 2, i_dma_rsp_ready = 0 -> only two fire, ready drops; raise ready -> data popped in order, third read then fires.
4. DMA read fire in the same cycle as a pop, credits = 1 -> credits stay 1, ready stays 1, no FIFO overflow.
5. i_psm_wren = i_psm_rden = 1 -> write performed, o_err = 1 and held until i_rst.
6. Assert i_rst with two DMA reads in flight -> the next cycle shows o_dma_rsp_valid = 0, credits = RSP_DEPTH, and no late push.
